// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the asynchronous FIFO (dest_clk domain).
// Converts the synchronized Gray write pointer, issues RAM reads, and buffers
// returned words in an output register plus a one-entry skid register.
// Optional feature macro: FIFO_RD_LEVEL_EN adds the registered rd_level port.
module fifo_rd_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              dest_clk,
   input  logic              rst_n,
   input  logic [ADDR_W:0]   wr_ptr_gray_sync,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic              empty
`ifdef FIFO_RD_LEVEL_EN
   ,
   output logic [ADDR_W:0]   rd_level
`endif
);

   logic [ADDR_W:0]   r_rd_ptr_bin;
   logic [ADDR_W:0]   r_rd_ptr_gray;
   logic              r_pend;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;

   logic [ADDR_W:0]   w_wr_ptr_bin;
   logic [ADDR_W:0]   w_rd_ptr_next;
   logic              w_mem_empty;
   logic [1:0]        w_occ;
   logic [1:0]        w_occ_left;
   logic              w_pop;
   logic              w_ren;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      w_wr_ptr_bin = '0;
      for (int unsigned i = 0; i < ADDR_W + 1; i++) begin
         w_wr_ptr_bin[i] = ^(wr_ptr_gray_sync >> i);
      end
   end

   // Occupancy, pop and read-issue decisions
   always_comb begin
      w_mem_empty   = (r_rd_ptr_bin == w_wr_ptr_bin);
      w_occ         = 2'(r_rd_valid) + 2'(r_skid_valid) + 2'(r_pend);
      w_pop         = r_rd_valid & rd_ready;
      w_occ_left    = w_occ - 2'(w_pop);
      w_ren         = !w_mem_empty && (w_occ_left < 2'd2);
      w_rd_ptr_next = r_rd_ptr_bin + (ADDR_W + 1)'(1);
   end

   assign mem_ren     = w_ren;
   assign mem_raddr   = r_rd_ptr_bin[ADDR_W-1:0];
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;
   assign rd_ptr_gray = r_rd_ptr_gray;
   assign empty       = w_mem_empty && (w_occ == 2'd0);

   // Read pointer (binary and Gray) and in-flight flag advance on each issued read
   always_ff @(posedge dest_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr_bin  <= '0;
         r_rd_ptr_gray <= '0;
         r_pend        <= 1'b0;
      end else begin
         r_pend <= w_ren;
         if (w_ren) begin
            r_rd_ptr_bin  <= w_rd_ptr_next;
            r_rd_ptr_gray <= w_rd_ptr_next ^ (w_rd_ptr_next >> 1);
         end
      end
   end

   // Output/skid stage: returning data goes to the output register when it is
   // free or draining, otherwise into skid; a pop refills from skid first
   always_ff @(posedge dest_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (w_pop) begin
         if (r_skid_valid) begin
            r_rd_data <= r_skid_data;
            if (r_pend) begin
               r_skid_data <= mem_rdata;
            end else begin
               r_skid_valid <= 1'b0;
            end
         end else if (r_pend) begin
            r_rd_data <= mem_rdata;
         end else begin
            r_rd_valid <= 1'b0;
         end
      end else if (r_pend) begin
         if (!r_rd_valid) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= mem_rdata;
         end else begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= mem_rdata;
         end
      end
   end

`ifdef FIFO_RD_LEVEL_EN
   logic [ADDR_W:0] r_rd_level;

   // Fill level: words still in RAM plus words in flight or held
   always_ff @(posedge dest_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_level <= '0;
      end else begin
         r_rd_level <= (w_wr_ptr_bin - r_rd_ptr_bin) + (ADDR_W + 1)'(w_occ);
      end
   end

   assign rd_level = r_rd_level;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: word-count reference model (written/issued/returned/popped).
module tb_fifo_rd_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int PMOD  = 2 << AW;

   logic          dest_clk = 1'b0;
   logic          rst_n;
   logic [AW:0]   wr_ptr_gray_sync;
   logic          mem_ren;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic [AW:0]   rd_ptr_gray;
   logic          empty;
`ifdef FIFO_RD_LEVEL_EN
   logic [AW:0]   rd_level;
`endif

   fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .dest_clk         (dest_clk),
      .rst_n            (rst_n),
      .wr_ptr_gray_sync (wr_ptr_gray_sync),
      .mem_ren          (mem_ren),
      .mem_raddr        (mem_raddr),
      .mem_rdata        (mem_rdata),
      .rd_valid         (rd_valid),
      .rd_ready         (rd_ready),
      .rd_data          (rd_data),
      .rd_ptr_gray      (rd_ptr_gray),
      .empty            (empty)
`ifdef FIFO_RD_LEVEL_EN
      ,
      .rd_level         (rd_level)
`endif
   );

   always #5 dest_clk = ~dest_clk;

   // Synchronous-read RAM written directly by the bench's write side
   logic [DW-1:0] ram [DEPTH];
   always @(posedge dest_clk) begin
      if (mem_ren) mem_rdata <= ram[mem_raddr];
   end

   int unsigned vecs = 0;
   int unsigned errs = 0;

   // Reference model state (counts of words since reset)
   int unsigned   wr_cnt, iss_cnt, ret_cnt, pop_cnt;
   logic [DW-1:0] words[$];
   int unsigned   exp_level;

   function automatic logic [31:0] gray(input int unsigned b);
      int unsigned m;
      m = b % PMOD;
      return 32'(m ^ (m >> 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      wr_cnt = 0; iss_cnt = 0; ret_cnt = 0; pop_cnt = 0; exp_level = 0;
      words.delete();
   endtask

   task automatic write_words(input int unsigned n, input logic [DW-1:0] fixed, input bit use_fixed);
      logic [DW-1:0] d;
      for (int unsigned k = 0; k < n; k++) begin
         d = use_fixed ? fixed : DW'($urandom);
         ram[wr_cnt % DEPTH] = d;
         words.push_back(d);
         wr_cnt++;
      end
      wr_ptr_gray_sync = (AW + 1)'(gray(wr_cnt));
   endtask

   // One clock cycle: check outputs at the falling edge, advance the model at the rising edge
   task automatic step();
      bit exp_valid, exp_pop, exp_ren;
      @(negedge dest_clk);
      exp_valid = (ret_cnt > pop_cnt);
      exp_pop   = exp_valid && rd_ready;
      exp_ren   = (iss_cnt != wr_cnt) && ((iss_cnt - pop_cnt - 32'(exp_pop)) < 2);
      chk("empty",       32'(empty),       32'(wr_cnt == pop_cnt));
      chk("rd_valid",    32'(rd_valid),    32'(exp_valid));
      chk("mem_ren",     32'(mem_ren),     32'(exp_ren));
      chk("mem_raddr",   32'(mem_raddr),   32'(iss_cnt % DEPTH));
      chk("rd_ptr_gray", 32'(rd_ptr_gray), gray(iss_cnt));
      if (exp_valid) chk("rd_data", 32'(rd_data), 32'(words[pop_cnt]));
`ifdef FIFO_RD_LEVEL_EN
      chk("rd_level", 32'(rd_level), exp_level);
`endif
      @(posedge dest_clk);
      exp_level = wr_cnt - pop_cnt;
      ret_cnt   = iss_cnt;
      iss_cnt   = iss_cnt + 32'(exp_ren);
      pop_cnt   = pop_cnt + 32'(exp_pop);
      #1;
   endtask

   task automatic steps(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) step();
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock edge
   task automatic do_reset(input string tag);
      #2;
      rst_n = 1'b0;
      wr_ptr_gray_sync = '0;
      #1;
      chk({tag, "_rd_valid"},    32'(rd_valid),    0);
      chk({tag, "_rd_data"},     32'(rd_data),     0);
      chk({tag, "_rd_ptr_gray"}, 32'(rd_ptr_gray), 0);
      chk({tag, "_empty"},       32'(empty),       1);
      chk({tag, "_mem_ren"},     32'(mem_ren),     0);
      chk({tag, "_mem_raddr"},   32'(mem_raddr),   0);
`ifdef FIFO_RD_LEVEL_EN
      chk({tag, "_rd_level"},    32'(rd_level),    0);
`endif
      model_clear();
      @(posedge dest_clk);
      @(posedge dest_clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned room, n, budget;
      rst_n = 1'b0;
      rd_ready = 1'b0;
      wr_ptr_gray_sync = '0;
      for (int i = 0; i < DEPTH; i++) ram[i] = '0;
      model_clear();

      // Reset state
      @(posedge dest_clk);
      @(posedge dest_clk);
      #1;
      chk("rst_empty",       32'(empty),       1);
      chk("rst_rd_valid",    32'(rd_valid),    0);
      chk("rst_rd_ptr_gray", 32'(rd_ptr_gray), 0);
      chk("rst_mem_ren",     32'(mem_ren),     0);
      chk("rst_rd_data",     32'(rd_data),     0);
      rst_n = 1'b1;
      steps(2);

      // Single word with latency, then one pop
      write_words(1, 8'hA5, 1'b1);
      step();
      steps(2);
      chk("t2_rd_data", 32'(rd_data), 32'hA5);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      step();
      chk("t2_empty_after_pop", 32'(empty), 1);

      // Streaming 8 words
      do_reset("t3rst");
      rd_ready = 1'b1;
      write_words(8, '0, 1'b0);
      steps(14);
      chk("t3_empty_end", 32'(empty), 1);

      // Backpressure: only two reads ahead of the consumer
      do_reset("t4rst");
      rd_ready = 1'b0;
      write_words(8, '0, 1'b0);
      steps(6);
      chk("t4_rd_ptr_gray", 32'(rd_ptr_gray), 3);
`ifdef FIFO_RD_LEVEL_EN
      chk("t4_rd_level", 32'(rd_level), 8);
`endif
      rd_ready = 1'b1;
      steps(14);
      chk("t4_empty_end", 32'(empty), 1);

      // Wrap through 40 words in random-size steps
      do_reset("t5rst");
      rd_ready = 1'b1;
      budget = 0;
      while ((pop_cnt < 40) && (budget < 400)) begin
         room = DEPTH - (wr_cnt - pop_cnt);
         n = $urandom_range(0, 4);
         if (n > room) n = room;
         if (n > 40 - wr_cnt) n = 40 - wr_cnt;
         if (n > 0) write_words(n, '0, 1'b0);
         step();
         budget++;
      end
      chk("t5_budget_ok", 32'(budget < 400), 1);
      step();
      chk("t5_empty_end", 32'(empty), 1);

      // Random traffic: bursty writes, multi-step pointer jumps, random backpressure
      for (int c = 0; c < 600; c++) begin
         rd_ready = (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
         room = DEPTH - (wr_cnt - pop_cnt);
         n = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : 0;
         if (n > room) n = room;
         if (n > 0) write_words(n, '0, 1'b0);
         step();
      end

      // Reset mid-burst with a word held and a read in flight
      do_reset("t6pre");
      rd_ready = 1'b1;
      write_words(8, '0, 1'b0);
      steps(3);
      chk("t6_valid_before", 32'(rd_valid), 1);
      chk("t6_pend_before",  32'(dut.r_pend), 1);
      do_reset("t6rst");
      steps(4);
      chk("t6_valid_after", 32'(rd_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
